// File: rtl/rf_wport_pkg.sv
// Shared types for the regfile write-port arbiter: widths, source encoding,
// hold FSM states and the queued long-latency result entry.
package rf_wport_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int PC_W       = 32;

    typedef enum logic [1:0] {
        SRC_NONE = 2'b00,
        SRC_WB   = 2'b01,
        SRC_LU   = 2'b10
    } rf_src_e;

    typedef enum logic {
        HOLD_IDLE   = 1'b0,
        HOLD_ACTIVE = 1'b1
    } hold_state_e;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] waddr;
        logic [DATA_W-1:0]     wdata;
        logic [PC_W-1:0]       pc;
    } rf_entry_t;

    localparam int ENTRY_W = $bits(rf_entry_t);

endpackage

// File: rtl/rf_wport_fifo.sv
// Small synchronous FIFO holding long-latency results until the write port
// is free. Full/empty come from pointers carrying one extra wrap bit.
module rf_wport_fifo
    import rf_wport_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_push,
    input  logic [ENTRY_W-1:0] i_data,
    input  logic               i_pop,
    output logic               o_full,
    output logic               o_empty,
    output logic [ENTRY_W-1:0] o_head
);

    localparam int AW = $clog2(DEPTH);

    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [AW:0]        r_wptr;
    logic [AW:0]        r_rptr;
    logic               w_push;
    logic               w_pop;

    assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_empty = (r_wptr == r_rptr);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_head  = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + (AW+1)'(1);
            if (w_pop)  r_rptr <= r_rptr + (AW+1)'(1);
        end
    end

    // Storage carries no reset; validity is defined solely by the pointers.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/rf_wport_arbiter.sv
// Regfile write-port arbiter: WB has priority, long-latency results drain from
// a FIFO on idle cycles, and a starvation guard forces a one-cycle WB hold.
module rf_wport_arbiter
    import rf_wport_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        wb_we,
    input  logic [4:0]  wb_waddr,
    input  logic [31:0] wb_wdata,
    input  logic [31:0] wb_pc,
    input  logic        lu_valid,
    output logic        lu_ready,
    input  logic [4:0]  lu_waddr,
    input  logic [31:0] lu_wdata,
    input  logic [31:0] lu_pc,
    output logic        wb_hold,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [31:0] debug_wb_pc,
    output logic [1:0]  rf_src
);

    localparam int CNT_W = $clog2(STARVE_MAX) + 1;

    rf_entry_t          w_lu_entry;
    rf_entry_t          w_head;
    logic [ENTRY_W-1:0] w_head_bits;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_starve_inc;
    rf_src_e            w_src;
    hold_state_e        r_state;
    hold_state_e        w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;

    assign w_lu_entry = '{waddr: lu_waddr, wdata: lu_wdata, pc: lu_pc};
    assign w_head     = rf_entry_t'(w_head_bits);
    assign lu_ready   = !w_full;
    assign w_push     = lu_valid && !w_full;
    assign w_pop      = (w_src == SRC_LU);

    rf_wport_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst_n (resetn),
        .i_push  (w_push),
        .i_data  (w_lu_entry),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head_bits)
    );

    // A hold cycle always finds the FIFO occupied, so the head can be taken blindly.
    always_comb begin
        w_src = SRC_NONE;
        if (!resetn)                     w_src = SRC_NONE;
        else if (r_state == HOLD_ACTIVE) w_src = SRC_LU;
        else if (wb_we)                  w_src = SRC_WB;
        else if (!w_empty)               w_src = SRC_LU;
    end

    always_comb begin
        rf_we       = 1'b0;
        rf_waddr    = '0;
        rf_wdata    = '0;
        debug_wb_pc = '0;
        case (w_src)
            SRC_WB: begin
                rf_we       = 1'b1;
                rf_waddr    = wb_waddr;
                rf_wdata    = wb_wdata;
                debug_wb_pc = wb_pc;
            end
            SRC_LU: begin
                rf_we       = 1'b1;
                rf_waddr    = w_head.waddr;
                rf_wdata    = w_head.wdata;
                debug_wb_pc = w_head.pc;
            end
            default: ;
        endcase
    end

    assign rf_src       = w_src;
    assign w_starve_inc = !w_empty && (w_src == SRC_WB);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt <= '0;
        end else if (w_empty || w_src == SRC_LU) begin
            r_cnt <= '0;
        end else if (w_starve_inc) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= HOLD_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Enter HOLD on the denial that brings the counter to STARVE_MAX.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            HOLD_IDLE:   if (w_starve_inc && r_cnt == CNT_W'(STARVE_MAX - 1)) w_state_nxt = HOLD_ACTIVE;
            HOLD_ACTIVE: w_state_nxt = HOLD_IDLE;
            default:     w_state_nxt = HOLD_IDLE;
        endcase
    end

    always_comb begin
        wb_hold = (r_state == HOLD_ACTIVE);
    end

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Randomized and directed bench for rf_wport_arbiter, compared each cycle
// against a queue-based reference model of the write-port sharing rules.
module tb_rf_wport_arbiter;

    localparam int DEPTH      = 2;
    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic [31:0] wb_pc;
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_waddr;
    logic [31:0] lu_wdata;
    logic [31:0] lu_pc;
    logic        wb_hold;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] debug_wb_pc;
    logic [1:0]  rf_src;

    always #5 clk = ~clk;

    rf_wport_arbiter #(
        .DEPTH      (DEPTH),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .wb_we       (wb_we),
        .wb_waddr    (wb_waddr),
        .wb_wdata    (wb_wdata),
        .wb_pc       (wb_pc),
        .lu_valid    (lu_valid),
        .lu_ready    (lu_ready),
        .lu_waddr    (lu_waddr),
        .lu_wdata    (lu_wdata),
        .lu_pc       (lu_pc),
        .wb_hold     (wb_hold),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .debug_wb_pc (debug_wb_pc),
        .rf_src      (rf_src)
    );

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
        logic [31:0] pc;
    } ent_t;

    // Reference model: pending results in arrival order, how many cycles the
    // oldest one has been refused, and whether the next cycle is a forced hold.
    ent_t m_q[$];
    int   m_denied;
    bit   m_hold;
    int   n_checks;
    int   n_fail;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_denied = 0;
        m_hold   = 0;
    endtask

    function automatic bit is_pending(input logic [4:0] a);
        foreach (m_q[i]) if (m_q[i].a == a) return 1'b1;
        return 1'b0;
    endfunction

    task automatic set_wb(input logic we, input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
        wb_we = we; wb_waddr = a; wb_wdata = d; wb_pc = pc;
    endtask

    task automatic set_lu(input logic v, input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
        lu_valid = v; lu_waddr = a; lu_wdata = d; lu_pc = pc;
    endtask

    // Compare outputs for the current cycle, then advance the model past the edge.
    task automatic check_cycle();
        int   src;
        bit   nonempty;
        bit   acc;
        ent_t h;
        #2;
        nonempty = (m_q.size() > 0);
        if (m_hold)        src = 2;
        else if (wb_we)    src = 1;
        else if (nonempty) src = 2;
        else               src = 0;
        h = '{a: 5'd0, d: 32'd0, pc: 32'd0};
        if (src == 1) h = '{a: wb_waddr, d: wb_wdata, pc: wb_pc};
        if (src == 2) h = m_q[0];
        check_eq("rf_src",   rf_src, src);
        check_eq("rf_we",    rf_we, src != 0);
        check_eq("rf_waddr", rf_waddr, h.a);
        check_eq("rf_wdata", rf_wdata, h.d);
        check_eq("dbg_pc",   debug_wb_pc, h.pc);
        check_eq("lu_ready", lu_ready, m_q.size() < DEPTH);
        check_eq("wb_hold",  wb_hold, m_hold);
        if (!m_hold && wb_we)
            assert (!is_pending(wb_waddr)) else $error("scoreboard precondition broken for r%0d", wb_waddr);
        acc = lu_valid && (m_q.size() < DEPTH);
        if (m_hold) begin
            m_hold   = 0;
            m_denied = 0;
        end else if (src == 1 && nonempty) begin
            m_denied++;
            if (m_denied == STARVE_MAX) m_hold = 1;
        end else begin
            m_denied = 0;
        end
        if (src == 2) void'(m_q.pop_front());
        if (acc) m_q.push_back('{a: lu_waddr, d: lu_wdata, pc: lu_pc});
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cyc();
        check_cycle();
        tick();
    endtask

    initial begin
        logic [4:0] a;
        bit         acc;
        int         pct;
        n_checks = 0;
        n_fail   = 0;
        resetn   = 1'b0;
        set_wb(1'b0, 5'd0, 32'd0, 32'd0);
        set_lu(1'b0, 5'd0, 32'd0, 32'd0);
        model_reset();
        repeat (2) @(negedge clk);

        // Reset with a live WB request, then the first write after release.
        set_wb(1'b1, 5'd5, 32'h1234, 32'h1c000000);
        #2;
        check_eq("rst_rf_we",    rf_we, 1'b0);
        check_eq("rst_lu_ready", lu_ready, 1'b1);
        check_eq("rst_wb_hold",  wb_hold, 1'b0);
        check_eq("rst_rf_src",   rf_src, 2'b00);
        @(negedge clk);
        resetn = 1'b1;
        check_cycle();
        check_eq("first_wb_src",  rf_src, 2'b01);
        check_eq("first_wb_addr", rf_waddr, 5'd5);
        check_eq("first_wb_data", rf_wdata, 32'h1234);
        tick();

        // Idle drain of a single long-latency result.
        set_wb(1'b0, 5'd0, 32'd0, 32'd0);
        set_lu(1'b1, 5'd7, 32'hDEADBEEF, 32'h1c000040);
        cyc();
        lu_valid = 1'b0;
        check_cycle();
        check_eq("drain_src",  rf_src, 2'b10);
        check_eq("drain_addr", rf_waddr, 5'd7);
        check_eq("drain_data", rf_wdata, 32'hDEADBEEF);
        check_eq("drain_pc",   debug_wb_pc, 32'h1c000040);
        tick();
        check_cycle();
        check_eq("drain_empty", rf_src, 2'b00);
        tick();

        // Back-pressure: two pushes fill the FIFO while WB keeps the port.
        set_wb(1'b1, 5'd1, 32'h11, 32'h1c000100);
        set_lu(1'b1, 5'd10, 32'hA0, 32'h1c000200);
        cyc();
        set_wb(1'b1, 5'd2, 32'h22, 32'h1c000104);
        set_lu(1'b1, 5'd11, 32'hA1, 32'h1c000204);
        cyc();
        set_wb(1'b1, 5'd3, 32'h33, 32'h1c000108);
        set_lu(1'b1, 5'd12, 32'hA2, 32'h1c000208);
        check_cycle();
        check_eq("bp_full_ready", lu_ready, 1'b0);
        tick();
        for (int i = 0; i < 8; i++) begin
            check_cycle();
            acc = lu_valid && lu_ready;
            tick();
            if (acc) lu_valid = 1'b0;
            if (!m_hold) set_wb(1'b1, 5'd4 + 5'(i % 4), 32'h40 + i, 32'h1c000110 + 4 * i);
        end
        set_wb(1'b0, 5'd0, 32'd0, 32'd0);
        lu_valid = 1'b0;
        repeat (6) cyc();

        // Starvation: continuous WB forces a hold on the fifth eligible cycle.
        set_wb(1'b1, 5'd2, 32'h200, 32'h1c000300);
        set_lu(1'b1, 5'd20, 32'hCAFE0020, 32'h1c000400);
        cyc();
        lu_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            check_cycle();
            check_eq("starve_hold", wb_hold, k == 5);
            if (k == 5) check_eq("starve_head", rf_waddr, 5'd20);
            if (k == 6) check_eq("starve_after", rf_src, 2'b01);
            tick();
        end

        // Simultaneous WB and queued head: WB first, head on the next idle cycle.
        set_wb(1'b0, 5'd0, 32'd0, 32'd0);
        set_lu(1'b1, 5'd9, 32'h99, 32'h1c000090);
        cyc();
        lu_valid = 1'b0;
        set_wb(1'b1, 5'd3, 32'h33, 32'h1c000030);
        check_cycle();
        check_eq("simul_wb_pc", debug_wb_pc, 32'h1c000030);
        tick();
        set_wb(1'b0, 5'd0, 32'd0, 32'd0);
        check_cycle();
        check_eq("simul_lu_pc", debug_wb_pc, 32'h1c000090);
        tick();

        // Asynchronous reset while a hold is active.
        set_wb(1'b1, 5'd4, 32'h400, 32'h1c000500);
        set_lu(1'b1, 5'd21, 32'h2121, 32'h1c000600);
        cyc();
        lu_valid = 1'b0;
        repeat (4) cyc();
        check_cycle();
        check_eq("mid_hold_on", wb_hold, 1'b1);
        resetn = 1'b0;
        #1;
        check_eq("mid_rst_hold",  wb_hold, 1'b0);
        check_eq("mid_rst_rf_we", rf_we, 1'b0);
        model_reset();
        @(negedge clk);
        resetn = 1'b1;
        set_wb(1'b0, 5'd0, 32'd0, 32'd0);
        check_cycle();
        check_eq("post_rst_empty", rf_src, 2'b00);
        tick();

        // Randomized traffic, light WB load first then heavy to provoke holds.
        for (int n = 0; n < 400; n++) begin
            pct = (n < 200) ? 50 : 90;
            if (!m_hold) begin
                a = 5'($urandom_range(0, 31));
                for (int t = 0; t < 64 && is_pending(a); t++) a = 5'($urandom_range(0, 31));
                set_wb($urandom_range(0, 99) < pct, a, $urandom, $urandom);
            end
            a = 5'($urandom_range(0, 31));
            if (a == wb_waddr) a = a + 5'd1;
            set_lu($urandom_range(0, 99) < 40, a, $urandom, $urandom);
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_wport_arbiter.md
# rf_wport_arbiter

Shares the single register-file write port between the in-order WB stage and the long-latency unit (divider/multiplier) result path. WB has priority. Long-latency results queue in a small FIFO and drain on WB-idle cycles. A starvation guard freezes the pipeline for one cycle when a queued result is denied too long. The block sits between WB, the long-latency unit and the regfile, and drives the debug writeback trace.

## Interface
Parameters:
- DEPTH, 2, long-latency result FIFO entries (power of 2, ≥2)
- STARVE_MAX, 4, consecutive denied cycles before a hold is forced (≥1)

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous, active-low reset
- wb_we  in  1  WB write request (already qualified by WB valid)
- wb_waddr  in  5  WB destination
- wb_wdata  in  32  WB result
- wb_pc  in  32  WB instruction pc
- lu_valid  in  1  long-latency result valid
- lu_ready  out  1  FIFO can accept (= !full)
- lu_waddr  in  5  long-latency destination
- lu_wdata  in  32  long-latency result
- lu_pc  in  32  long-latency instruction pc
- wb_hold  out  1  registered; pipeline-freeze request for this cycle
- rf_we  out  1  regfile write enable
- rf_waddr  out  5  regfile write address
- rf_wdata  out  32  regfile write data
- debug_wb_pc  out  32  pc of the committed write
- rf_src  out  2  00 none, 01 WB, 10 FIFO head

## Operation
- Enqueue: lu_valid && lu_ready pushes {waddr, wdata, pc}. lu_ready is !full only; no same-cycle pass-through when full and dequeuing.
- Grant, combinational each cycle:
  - if wb_hold: FIFO head (non-empty is guaranteed).
  - else if wb_we: WB.
  - else if FIFO non-empty: head.
  - else none.
- Outputs follow the selected source. With none: rf_we=0, rf_waddr=0, rf_wdata=0, debug_wb_pc=0.
- A head grant pops the FIFO the same cycle.
- Starvation counter (width clog2(STARVE_MAX)+1) increments when the FIFO is non-empty and WB wins. It clears on a head grant or when the FIFO is empty.
- FSM IDLE→HOLD: on the cycle the counter reaches STARVE_MAX. wb_hold=1 in the next cycle.
- FSM HOLD→IDLE: unconditionally after one cycle; the counter clears.
- During HOLD, wb_* inputs are ignored. Upstream keeps the WB instruction stable and re-presents it the following cycle.
- Precondition: the ID-stage scoreboard guarantees no WB instruction targets a register with a pending FIFO write. The arbiter does not reorder. The bench asserts this precondition.
- Writes to r0 pass through unchanged; the regfile ignores them.

## Timing
- Reset (resetn low, asynchronous):
  - FIFO empty, counter 0, FSM IDLE.
  - wb_hold=0, lu_ready=1, rf_src=00.
  - rf_we forced 0 while resetn is low.
- Reset mid-operation discards queued results.
- WB→regfile latency: 0 cycles (combinational pass-through).
- Long-latency enqueue→write: minimum 1 cycle (enqueue in cycle N, eligible in N+1).
- FIFO full + pop in the same cycle: lu_ready stays 0 that cycle; it rises the next cycle.
- Empty + push: not eligible until the next cycle.
- Pointers wrap modulo DEPTH. Full/empty are tracked with an extra pointer bit.
- Worst-case head wait with continuous WB: STARVE_MAX+1 cycles.

## Structure
- Shared package rf_wport_pkg:
  - REG_ADDR_W=5, DATA_W=32.
  - rf_src encodings SRC_NONE/SRC_WB/SRC_LU.
  - FSM state enum HOLD_IDLE/HOLD_ACTIVE.
  - FIFO entry struct {waddr, wdata, pc}.
- Sub-module rf_wport_fifo: parameterised synchronous FIFO with push/pop/full/empty/head and asynchronous active-low reset.
- Top contains the grant mux, starvation counter and hold FSM.

## Test plan
- Reset: resetn low with wb_we=1 → rf_we=0, lu_ready=1, wb_hold=0. Release → next WB write (r5, 0x1234, pc 0x1c000000) appears same cycle with rf_src=01.
- Idle drain: push lu (r7, 0xDEADBEEF, pc 0x1c000040) with wb_we=0 → next cycle rf_we=1, r7, 0xDEADBEEF, debug_wb_pc=0x1c000040, rf_src=10; FIFO empty after.
- Back-pressure: push 2 entries while wb_we=1 continuously → lu_ready=0 after the second push. The third lu_valid is not accepted until a pop.
- Starvation: wb_we=1 every cycle, one queued entry, STARVE_MAX=4 → wb_hold=1 exactly in the 5th cycle after enqueue-eligibility. Head written that cycle, then wb_hold=0 and the counter is back at 0.
- Simultaneous: wb_we=1 (r3) and FIFO head (r9) in the same non-hold cycle → r3 written, r9 written on the first cycle wb_we=0. Order is checked against debug_wb_pc.
- Async reset mid-hold: resetn low during wb_hold=1 → wb_hold, rf_we drop immediately. FIFO is empty after release.
